// File: rtl/ls_output_slicer.sv
// rtl/ls_output_slicer.sv - hysteresis slicer with debounce and supply-fault detection
// Optional edge counter (CNT_CLR/EDGE_CNT) is built when SLICER_EDGE_CNT_EN is defined.
module ls_output_slicer #(
  parameter real VTH_HI_FRAC = 0.6,
  parameter real VTH_LO_FRAC = 0.4,
  parameter int  DEBOUNCE    = 4,
  parameter real VCC_MIN     = 1.0
`ifdef SLICER_EDGE_CNT_EN
  ,
  parameter int  CNT_W       = 16
`endif
) (
  input  logic CLK,
  input  logic RST,
  input  real  VIN,
  input  real  VCC_HIGH,
  output logic DOUT,
  output logic RISE,
  output logic FALL,
  output logic FAULT
`ifdef SLICER_EDGE_CNT_EN
  ,
  input  logic             CNT_CLR,
  output logic [CNT_W-1:0] EDGE_CNT
`endif
);

  if (VTH_LO_FRAC >= VTH_HI_FRAC) begin : g_bad_thresh
    $fatal(1, "ls_output_slicer: VTH_LO_FRAC must be below VTH_HI_FRAC");
  end
  if (DEBOUNCE < 1) begin : g_bad_debounce
    $fatal(1, "ls_output_slicer: DEBOUNCE must be at least 1");
  end
  if (VCC_MIN <= 0.0) begin : g_bad_vccmin
    $fatal(1, "ls_output_slicer: VCC_MIN must be positive");
  end

  localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE - 1);
  localparam bit DEB_ONE = (DEBOUNCE == 1);

  typedef enum logic [2:0] {
    LOW    = 3'd0,
    PEND_H = 3'd1,
    HIGH   = 3'd2,
    PEND_L = 3'd3,
    FLT    = 3'd4
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  real  vth_hi;
  real  vth_lo;
  logic is_hi;
  logic is_lo;
  logic supply_ok;
  logic rise_evt;
  logic fall_evt;

  // Thresholds track the live supply so the hysteresis window scales with VCC_HIGH.
  assign vth_hi    = VTH_HI_FRAC * VCC_HIGH;
  assign vth_lo    = VTH_LO_FRAC * VCC_HIGH;
  assign is_hi     = (VIN >= vth_hi);
  assign is_lo     = (VIN <= vth_lo);
  assign supply_ok = (VCC_HIGH >= VCC_MIN);

  assign rise_evt = supply_ok && is_hi &&
                    ((state == LOW && DEB_ONE) || (state == PEND_H && cnt == DEB_LAST));
  assign fall_evt = supply_ok && is_lo &&
                    ((state == HIGH && DEB_ONE) || (state == PEND_L && cnt == DEB_LAST));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= LOW;
      cnt   <= '0;
      DOUT  <= 1'b0;
      RISE  <= 1'b0;
      FALL  <= 1'b0;
      FAULT <= 1'b0;
    end else begin
      RISE <= 1'b0;
      FALL <= 1'b0;
      if (!supply_ok) begin
        // Collapse drops DOUT silently: no FALL, since the level is not a real transition.
        state <= FLT;
        cnt   <= '0;
        DOUT  <= 1'b0;
        FAULT <= 1'b1;
      end else begin
        case (state)
          FLT: begin
            state <= LOW;
            cnt   <= '0;
            FAULT <= 1'b0;
          end
          LOW: begin
            if (rise_evt) begin
              state <= HIGH;
              DOUT  <= 1'b1;
              RISE  <= 1'b1;
            end else if (is_hi) begin
              state <= PEND_H;
              cnt   <= CW'(1);
            end
          end
          PEND_H: begin
            if (rise_evt) begin
              state <= HIGH;
              cnt   <= '0;
              DOUT  <= 1'b1;
              RISE  <= 1'b1;
            end else if (is_hi) begin
              cnt <= cnt + 1'b1;
            end else begin
              state <= LOW;
              cnt   <= '0;
            end
          end
          HIGH: begin
            if (fall_evt) begin
              state <= LOW;
              DOUT  <= 1'b0;
              FALL  <= 1'b1;
            end else if (is_lo) begin
              state <= PEND_L;
              cnt   <= CW'(1);
            end
          end
          PEND_L: begin
            if (fall_evt) begin
              state <= LOW;
              cnt   <= '0;
              DOUT  <= 1'b0;
              FALL  <= 1'b1;
            end else if (is_lo) begin
              cnt <= cnt + 1'b1;
            end else begin
              state <= HIGH;
              cnt   <= '0;
            end
          end
          default: begin
            state <= LOW;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

`ifdef SLICER_EDGE_CNT_EN
  // Counts on the same edge that raises RISE/FALL; clear beats increment.
  always_ff @(posedge CLK) begin
    if (RST || CNT_CLR) begin
      EDGE_CNT <= '0;
    end else if ((rise_evt || fall_evt) && (EDGE_CNT != {CNT_W{1'b1}})) begin
      EDGE_CNT <= EDGE_CNT + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ls_output_slicer.sv
// tb/tb_ls_output_slicer.sv - randomized bench for ls_output_slicer against a run-length model
// Exercises the edge counter as well when SLICER_EDGE_CNT_EN is defined.
module tb_ls_output_slicer;

  localparam int  DEB  = 4;
`ifdef SLICER_EDGE_CNT_EN
  localparam int  CW_T = 2;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  real  vin = 0.0;
  real  vcc_high = 1.8;
  logic dout, rise, fall, fault;
`ifdef SLICER_EDGE_CNT_EN
  logic            cnt_clr = 1'b0;
  logic [CW_T-1:0] edge_cnt;
`endif

  int checks = 0;
  int errors = 0;

  ls_output_slicer #(
    .VTH_HI_FRAC(0.6),
    .VTH_LO_FRAC(0.4),
    .DEBOUNCE(DEB),
    .VCC_MIN(1.0)
`ifdef SLICER_EDGE_CNT_EN
    ,
    .CNT_W(CW_T)
`endif
  ) dut (
    .CLK(clk),
    .RST(rst),
    .VIN(vin),
    .VCC_HIGH(vcc_high),
    .DOUT(dout),
    .RISE(rise),
    .FALL(fall),
    .FAULT(fault)
`ifdef SLICER_EDGE_CNT_EN
    ,
    .CNT_CLR(cnt_clr),
    .EDGE_CNT(edge_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the output flips once DEB consecutive samples sit beyond the threshold
  // opposite the current level; a collapsed supply forces zero and costs one recovery edge.
  bit   started = 0;
  bit   m_dout, m_rise, m_fall, m_fault;
  int   run;
  int   m_ecnt;

  always @(posedge clk) begin
    bit qual;
    if (rst) begin
      started = 1;
      m_dout = 0; m_rise = 0; m_fall = 0; m_fault = 0; run = 0; m_ecnt = 0;
    end else begin
      m_rise = 0; m_fall = 0;
      if (vcc_high < 1.0) begin
        m_fault = 1; m_dout = 0; run = 0;
      end else if (m_fault) begin
        m_fault = 0; run = 0;
      end else begin
        qual = m_dout ? (vin <= 0.4 * vcc_high) : (vin >= 0.6 * vcc_high);
        run  = qual ? run + 1 : 0;
        if (run == DEB) begin
          m_dout = !m_dout;
          m_rise = m_dout;
          m_fall = !m_dout;
          run    = 0;
        end
      end
`ifdef SLICER_EDGE_CNT_EN
      if (cnt_clr) m_ecnt = 0;
      else if ((m_rise || m_fall) && m_ecnt < (1 << CW_T) - 1) m_ecnt++;
`endif
    end
    #1;
    if (started) begin
      chk("dout",  {31'b0, dout},  {31'b0, m_dout});
      chk("rise",  {31'b0, rise},  {31'b0, m_rise});
      chk("fall",  {31'b0, fall},  {31'b0, m_fall});
      chk("fault", {31'b0, fault}, {31'b0, m_fault});
      chk("rise_fall_excl", {31'b0, rise & fall}, 32'd0);
`ifdef SLICER_EDGE_CNT_EN
      chk("edge_cnt", {30'b0, edge_cnt}, 32'(m_ecnt));
`endif
    end
  end

  task automatic apply(input real v, input real vcc, input int n);
    vin = v;
    vcc_high = vcc;
    repeat (n) @(negedge clk);
  endtask

  real vins[8] = '{0.0, 0.5, 0.70, 0.72, 0.9, 1.08, 1.2, 1.8};

  initial begin
    @(negedge clk);
    rst = 1'b1;
    apply(1.8, 1.8, 2);
    chk("reset_dout", {31'b0, dout}, 32'd0);
    chk("reset_fault", {31'b0, fault}, 32'd0);
    rst = 1'b0;
    apply(1.8, 1.8, 3);
    chk("rel_edge3_dout", {31'b0, dout}, 32'd0);
    apply(1.8, 1.8, 1);
    chk("rel_edge4_dout", {31'b0, dout}, 32'd1);
    chk("rel_edge4_rise", {31'b0, rise}, 32'd1);
    apply(1.8, 1.8, 1);
    chk("rise_clears", {31'b0, rise}, 32'd0);

    apply(0.0, 1.8, 4);
    chk("back_low", {31'b0, dout}, 32'd0);
    apply(1.8, 1.8, 3);
    apply(0.0, 1.8, 1);
    chk("glitch3_dout", {31'b0, dout}, 32'd0);
    apply(1.8, 1.8, 4);
    chk("run4_dout", {31'b0, dout}, 32'd1);

    apply(0.9, 1.8, 100);
    chk("mid_hold_high", {31'b0, dout}, 32'd1);
    apply(0.70, 1.8, 3);
    chk("fall_pend_dout", {31'b0, dout}, 32'd1);
    apply(0.70, 1.8, 1);
    chk("fall_dout", {31'b0, dout}, 32'd0);
    chk("fall_pulse", {31'b0, fall}, 32'd1);

    apply(0.9, 1.8, 100);
    chk("mid_hold_low", {31'b0, dout}, 32'd0);

    apply(1.8, 1.8, 4);
    chk("pre_fault_high", {31'b0, dout}, 32'd1);
    apply(1.8, 0.8, 1);
    chk("fault_set", {31'b0, fault}, 32'd1);
    chk("fault_dout", {31'b0, dout}, 32'd0);
    chk("fault_no_fall", {31'b0, fall}, 32'd0);
    apply(1.8, 1.8, 1);
    chk("fault_clear", {31'b0, fault}, 32'd0);
    chk("fault_exit_dout", {31'b0, dout}, 32'd0);
    apply(1.8, 1.8, 3);
    chk("recover3_dout", {31'b0, dout}, 32'd0);
    apply(1.8, 1.8, 1);
    chk("recover4_dout", {31'b0, dout}, 32'd1);

`ifdef SLICER_EDGE_CNT_EN
    rst = 1'b1;
    apply(0.0, 1.8, 1);
    rst = 1'b0;
    for (int t = 0; t < 2; t++) begin
      apply(1.8, 1.8, 4);
      apply(0.0, 1.8, 4);
    end
    apply(1.8, 1.8, 4);
    apply(0.0, 1.8, 4);
    chk("edge_cnt_sat", {30'b0, edge_cnt}, 32'd3);
    apply(1.8, 1.8, 3);
    cnt_clr = 1'b1;
    apply(1.8, 1.8, 1);
    chk("clr_on_rise_pulse", {31'b0, rise}, 32'd1);
    chk("clr_on_rise_cnt", {30'b0, edge_cnt}, 32'd0);
    cnt_clr = 1'b0;
`endif

    for (int s = 0; s < 400; s++) begin
      int r;
      real vc;
      r = $urandom_range(0, 99);
      if (r < 80)      vc = 1.8;
      else if (r < 88) vc = 3.3;
      else if (r < 94) vc = 1.0;
      else             vc = 0.8;
      rst = ($urandom_range(0, 99) < 2);
`ifdef SLICER_EDGE_CNT_EN
      cnt_clr = ($urandom_range(0, 99) < 5);
`endif
      apply(vins[$urandom_range(0, 7)], vc, $urandom_range(1, 6));
    end
    rst = 1'b0;
    apply(0.0, 1.8, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ls_output_slicer.md
Name: ls_output_slicer

Overview:
Downstream stage of level_shifter. Consumes the real-valued VOUT of the shifter and produces a clean, debounced logic level in the CLK domain. Applies hysteresis thresholds that scale with VCC_HIGH and filters glitches with a consecutive-sample counter. Flags a supply fault when VCC_HIGH collapses.

Parameters:
VTH_HI_FRAC, 0.6, rising threshold as a fraction of VCC_HIGH (real)
VTH_LO_FRAC, 0.4, falling threshold as a fraction of VCC_HIGH (real); must be < VTH_HI_FRAC
DEBOUNCE, 4, consecutive qualifying samples required to change DOUT; must be >= 1
VCC_MIN, 1.0, minimum valid VCC_HIGH in volts (real)
CNT_W, 16, EDGE_CNT width (only with SLICER_EDGE_CNT_EN)

Ports:
CLK  input  1  sampling clock; all state updates on the rising edge
RST  input  1  reset, synchronous, active-high
VIN  input  real  analog level; driven by level_shifter VOUT
VCC_HIGH  input  real  high-side supply; same net as level_shifter VCC_HIGH
DOUT  output  1  debounced logic level
RISE  output  1  one-cycle pulse on the cycle DOUT goes 0->1
FALL  output  1  one-cycle pulse on the cycle DOUT goes 1->0
FAULT  output  1  high while supply invalid
CNT_CLR  input  1  synchronous clear of EDGE_CNT (present only with SLICER_EDGE_CNT_EN)
EDGE_CNT  output  CNT_W  transition count (present only with SLICER_EDGE_CNT_EN)

Behaviour:
- One clock: CLK. Reset is synchronous and active-high: RST.
- Reset (RST=1 at an edge): state=LOW, cnt=0, DOUT=0, RISE=0, FALL=0, FAULT=0, EDGE_CNT=0. RST overrides all other inputs.
- Every edge, compute vth_hi=VTH_HI_FRAC*VCC_HIGH and vth_lo=VTH_LO_FRAC*VCC_HIGH from current values.
- Classify the sample: HI if VIN>=vth_hi; LO if VIN<=vth_lo; MID otherwise.
- States: LOW, PEND_H, HIGH, PEND_L, FLT.
- Supply check has priority. If VCC_HIGH<VCC_MIN in any state, next state is FLT, cnt=0, DOUT=0 and FAULT=1. No FALL pulse is generated, even when leaving HIGH or PEND_L.
- FLT exit: when VCC_HIGH>=VCC_MIN, go to LOW with FAULT=0 and cnt=0. The current sample is not counted.
- LOW, DEBOUNCE=1: HI goes directly to HIGH.
- LOW, DEBOUNCE>1: HI goes to PEND_H with cnt=1. MID or LO stays in LOW.
- PEND_H: HI increments cnt. When cnt+1==DEBOUNCE, go to HIGH, DOUT=1, RISE=1. MID or LO returns to LOW with cnt=0.
- HIGH and PEND_L mirror LOW and PEND_H with LO as the qualifying class. Exit from PEND_L is to HIGH. The transition sets DOUT=0 and FALL=1.
- MID never changes DOUT. It holds in LOW and HIGH, and aborts PEND_H and PEND_L.
- Latency: DOUT updates at the edge that captures the DEBOUNCE-th consecutive qualifying sample.
- RISE and FALL are registered, asserted in the same cycle DOUT changes, and cleared the next cycle. They are never both high.
- Parameter check: VTH_LO_FRAC>=VTH_HI_FRAC, DEBOUNCE<1 or VCC_MIN<=0 causes $fatal at time 0.

Optional Feature:
SLICER_EDGE_CNT_EN
- Defined: CNT_CLR and EDGE_CNT exist. EDGE_CNT increments on any edge where RISE or FALL is set. It saturates at 2**CNT_W-1. CNT_CLR=1 forces 0 and wins over a simultaneous increment. RST also clears it.
- Undefined: both ports and the counter logic are absent. All other behaviour is identical.

Test Plan:
- RST=1 for 2 cycles with VCC_HIGH=1.8, VIN=1.8, then release -> DOUT=0 during reset. DOUT=1 with a single RISE pulse at the 4th edge after release. FAULT=0 throughout.
- From LOW, VIN=1.8 for 3 cycles, then 0.0 -> DOUT stays 0, no RISE. Then VIN=1.8 for 4 cycles -> DOUT=1.
- From HIGH (VCC_HIGH=1.8, so vth_hi=1.08 and vth_lo=0.72), VIN=0.9 for 100 cycles -> DOUT stays 1. Then VIN=0.70 -> FALL and DOUT=0 on the 4th sample.
- From LOW, VIN=0.9 for 100 cycles -> DOUT stays 0 and no pulses.
- From HIGH, VCC_HIGH=0.8 -> next edge FAULT=1, DOUT=0, FALL=0. Restore VCC_HIGH=1.8 with VIN=1.8 -> FAULT=0 after 1 edge, then DOUT=1 after 4 further edges.
- With SLICER_EDGE_CNT_EN and CNT_W=2: 3 full toggles -> EDGE_CNT=3 (saturated). Assert CNT_CLR on a RISE cycle -> EDGE_CNT=0.
